// File: rtl/axi_master_arbiter_if.sv
// Bundle of every bus signal around axi_master_arbiter.
//   m_* : two requesters (M0 = instruction fetch, M1 = load/store), packed
//         per requester with Mi at slice i.
//   s_* : the single downstream AXI4 master port toward axi_bridge.
// Modport master is the arbiter's view (it owns the downstream master
// port); modport slave is the surrounding environment: the requesters and
// the downstream slave.
interface axi_master_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Requester side
    logic [1:0]              m_awvalid;
    logic [2*ADDR_WIDTH-1:0] m_awaddr;
    logic [15:0]             m_awlen;
    logic [5:0]              m_awsize;
    logic [3:0]              m_awburst;
    logic [1:0]              m_awready;
    logic [1:0]              m_wvalid;
    logic [1:0]              m_wlast;
    logic [2*DATA_WIDTH-1:0] m_wdata;
    logic [2*STRB_WIDTH-1:0] m_wstrb;
    logic [1:0]              m_wready;
    logic [1:0]              m_bvalid;
    logic [1:0]              m_bresp;
    logic [1:0]              m_bready;
    logic [1:0]              m_arvalid;
    logic [2*ADDR_WIDTH-1:0] m_araddr;
    logic [15:0]             m_arlen;
    logic [5:0]              m_arsize;
    logic [3:0]              m_arburst;
    logic [1:0]              m_arready;
    logic [1:0]              m_rvalid;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rlast;
    logic [1:0]              m_rready;

    // Downstream side
    logic                    s_awvalid;
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic [7:0]              s_awlen;
    logic [2:0]              s_awsize;
    logic [1:0]              s_awburst;
    logic [ID_WIDTH-1:0]     s_awid;
    logic                    s_awready;
    logic                    s_wvalid;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [STRB_WIDTH-1:0]   s_wstrb;
    logic                    s_wlast;
    logic                    s_wready;
    logic                    s_bvalid;
    logic [1:0]              s_bresp;
    logic [ID_WIDTH-1:0]     s_bid;
    logic                    s_bready;
    logic                    s_arvalid;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic [7:0]              s_arlen;
    logic [2:0]              s_arsize;
    logic [1:0]              s_arburst;
    logic [ID_WIDTH-1:0]     s_arid;
    logic                    s_arready;
    logic                    s_rvalid;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic [ID_WIDTH-1:0]     s_rid;
    logic                    s_rlast;
    logic                    s_rready;

    modport master (
        input  m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        output m_awready,
        input  m_wvalid, m_wlast, m_wdata, m_wstrb,
        output m_wready,
        output m_bvalid, m_bresp,
        input  m_bready,
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst,
        output m_arready,
        output m_rvalid, m_rdata, m_rresp, m_rlast,
        input  m_rready,
        output s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
        input  s_awready,
        output s_wvalid, s_wdata, s_wstrb, s_wlast,
        input  s_wready,
        input  s_bvalid, s_bresp, s_bid,
        output s_bready,
        output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid,
        input  s_arready,
        input  s_rvalid, s_rdata, s_rresp, s_rid, s_rlast,
        output s_rready
    );

    modport slave (
        output m_awvalid, m_awaddr, m_awlen, m_awsize, m_awburst,
        input  m_awready,
        output m_wvalid, m_wlast, m_wdata, m_wstrb,
        input  m_wready,
        input  m_bvalid, m_bresp,
        output m_bready,
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rresp, m_rlast,
        output m_rready,
        input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awid,
        output s_awready,
        input  s_wvalid, s_wdata, s_wstrb, s_wlast,
        output s_wready,
        output s_bvalid, s_bresp, s_bid,
        input  s_bready,
        input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arid,
        output s_arready,
        output s_rvalid, s_rdata, s_rresp, s_rid, s_rlast,
        input  s_rready
    );
endinterface

// File: rtl/axi_master_arbiter.sv
// Two-requester AXI4 arbiter in front of the single SoC master port.
// Read and write channels are arbitrated independently with round-robin,
// one outstanding transaction per channel, locked to the owner from
// address grant until the last read beat or the write response.
// Ports:
//   aclk   : clock, rising edge
//   areset : synchronous active-high reset
//   bus    : all requester (m_*) and downstream (s_*) signals
module axi_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input logic                  aclk,
    input logic                  areset,
    axi_master_arbiter_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {ArIdle, ArAddr, ArData} ar_state_t;
    typedef enum logic [1:0] {WIdle, WAddr, WData, WResp} w_state_t;

    ar_state_t ar_state;
    logic      rgnt;
    logic      rptr;
    w_state_t  w_state;
    logic      wgnt;
    logic      wptr;

    logic      r_pick;
    logic      w_pick;

    // Transaction IDs are not needed for routing: the owner is held in the grant.
    logic      unused_ids;
    assign unused_ids = ^{bus.s_rid, bus.s_bid};

    // Single request wins outright; a tie goes to the pointer's master.
    function automatic logic pick(input logic [1:0] req, input logic ptr);
        return (req == 2'b11) ? ptr : req[1];
    endfunction

    assign r_pick = pick(bus.m_arvalid, rptr);
    assign w_pick = pick(bus.m_awvalid, wptr);

    // Read channel FSM
    always_ff @(posedge aclk) begin
        if (areset) begin
            ar_state <= ArIdle;
            rgnt     <= 1'b0;
            rptr     <= 1'b0;
        end else begin
            case (ar_state)
                ArIdle: begin
                    if (|bus.m_arvalid) begin
                        rgnt     <= r_pick;
                        rptr     <= ~r_pick;
                        ar_state <= ArAddr;
                    end
                end
                ArAddr: begin
                    if (bus.m_arvalid[rgnt] && bus.s_arready) ar_state <= ArData;
                end
                ArData: begin
                    if (bus.s_rvalid && bus.m_rready[rgnt] && bus.s_rlast) ar_state <= ArIdle;
                end
                default: ar_state <= ArIdle;
            endcase
        end
    end

    // Write channel FSM
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= WIdle;
            wgnt    <= 1'b0;
            wptr    <= 1'b0;
        end else begin
            case (w_state)
                WIdle: begin
                    if (|bus.m_awvalid) begin
                        wgnt    <= w_pick;
                        wptr    <= ~w_pick;
                        w_state <= WAddr;
                    end
                end
                WAddr: begin
                    if (bus.m_awvalid[wgnt] && bus.s_awready) w_state <= WData;
                end
                WData: begin
                    if (bus.m_wvalid[wgnt] && bus.s_wready && bus.m_wlast[wgnt]) begin
                        w_state <= WResp;
                    end
                end
                WResp: begin
                    if (bus.s_bvalid && bus.m_bready[wgnt]) w_state <= WIdle;
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // Read routing. Payload muxes follow the grant unconditionally; only the
    // valid/ready strobes are gated by state.
    always_comb begin
        bus.s_araddr  = rgnt ? bus.m_araddr[ADDR_WIDTH +: ADDR_WIDTH]
                             : bus.m_araddr[0 +: ADDR_WIDTH];
        bus.s_arlen   = rgnt ? bus.m_arlen[15:8]  : bus.m_arlen[7:0];
        bus.s_arsize  = rgnt ? bus.m_arsize[5:3]  : bus.m_arsize[2:0];
        bus.s_arburst = rgnt ? bus.m_arburst[3:2] : bus.m_arburst[1:0];
        bus.s_arid    = ID_WIDTH'(rgnt);
        bus.s_arvalid = 1'b0;
        bus.m_arready = 2'b00;
        bus.s_rready  = 1'b0;
        bus.m_rvalid  = 2'b00;
        bus.m_rdata   = bus.s_rdata;
        bus.m_rresp   = bus.s_rresp;
        bus.m_rlast   = bus.s_rlast;
        if (ar_state == ArAddr) begin
            bus.s_arvalid       = bus.m_arvalid[rgnt];
            bus.m_arready[rgnt] = bus.s_arready;
        end
        if (ar_state == ArData) begin
            bus.s_rready       = bus.m_rready[rgnt];
            bus.m_rvalid[rgnt] = bus.s_rvalid;
        end
    end

    // Write routing; W beats are held off until the AW handshake completes.
    always_comb begin
        bus.s_awaddr  = wgnt ? bus.m_awaddr[ADDR_WIDTH +: ADDR_WIDTH]
                             : bus.m_awaddr[0 +: ADDR_WIDTH];
        bus.s_awlen   = wgnt ? bus.m_awlen[15:8]  : bus.m_awlen[7:0];
        bus.s_awsize  = wgnt ? bus.m_awsize[5:3]  : bus.m_awsize[2:0];
        bus.s_awburst = wgnt ? bus.m_awburst[3:2] : bus.m_awburst[1:0];
        bus.s_awid    = ID_WIDTH'(wgnt);
        bus.s_wdata   = wgnt ? bus.m_wdata[DATA_WIDTH +: DATA_WIDTH]
                             : bus.m_wdata[0 +: DATA_WIDTH];
        bus.s_wstrb   = wgnt ? bus.m_wstrb[STRB_WIDTH +: STRB_WIDTH]
                             : bus.m_wstrb[0 +: STRB_WIDTH];
        bus.s_wlast   = bus.m_wlast[wgnt];
        bus.s_awvalid = 1'b0;
        bus.m_awready = 2'b00;
        bus.s_wvalid  = 1'b0;
        bus.m_wready  = 2'b00;
        bus.s_bready  = 1'b0;
        bus.m_bvalid  = 2'b00;
        bus.m_bresp   = bus.s_bresp;
        case (w_state)
            WAddr: begin
                bus.s_awvalid       = bus.m_awvalid[wgnt];
                bus.m_awready[wgnt] = bus.s_awready;
            end
            WData: begin
                bus.s_wvalid       = bus.m_wvalid[wgnt];
                bus.m_wready[wgnt] = bus.s_wready;
            end
            WResp: begin
                bus.s_bready       = bus.m_bready[wgnt];
                bus.m_bvalid[wgnt] = bus.s_bvalid;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_axi_master_arbiter.sv
// Directed self-checking bench for axi_master_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from the next edge.
module tb_axi_master_arbiter;
    logic aclk;
    logic areset;
    int   total;
    int   bad;
    int   rb;
    int   wb;
    logic rr;
    logic bdone;

    axi_master_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) bus ();

    axi_master_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .ID_WIDTH  (4)
    ) dut (
        .aclk  (aclk),
        .areset(areset),
        .bus   (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m_awvalid = '0; bus.m_awaddr = '0; bus.m_awlen = '0;
        bus.m_awsize  = '0; bus.m_awburst = '0;
        bus.m_wvalid  = '0; bus.m_wlast = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
        bus.m_bready  = '0;
        bus.m_arvalid = '0; bus.m_araddr = '0; bus.m_arlen = '0;
        bus.m_arsize  = '0; bus.m_arburst = '0;
        bus.m_rready  = '0;
        bus.s_awready = 1'b0; bus.s_wready = 1'b0;
        bus.s_bvalid  = 1'b0; bus.s_bresp = '0; bus.s_bid = '0;
        bus.s_arready = 1'b0;
        bus.s_rvalid  = 1'b0; bus.s_rdata = '0; bus.s_rresp = '0;
        bus.s_rid     = '0; bus.s_rlast = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        areset = 1'b1;
        cyc();
        areset = 1'b0;
    endtask

    // One read with both masters requesting; exp is the master that must win.
    task automatic rd_txn(input logic exp);
        settle();
        chk("rr_arb_idle", bus.s_arvalid, 0);
        cyc();
        settle();
        chk("rr_arid", bus.s_arid, exp ? 1 : 0);
        chk("rr_araddr", bus.s_araddr, exp ? 64'hB0 : 64'hA0);
        chk("rr_arready", bus.m_arready, exp ? 2'b10 : 2'b01);
        cyc();
        bus.s_rvalid = 1'b1;
        bus.s_rlast  = 1'b1;
        settle();
        chk("rr_rvalid", bus.m_rvalid, exp ? 2'b10 : 2'b01);
        cyc();
        bus.s_rvalid = 1'b0;
        bus.s_rlast  = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        areset = 1'b1;
        clear_inputs();
        cyc();
        cyc();
        areset = 1'b0;

        // Reset state: all strobes low
        bus.m_rready = 2'b11;
        bus.m_bready = 2'b11;
        settle();
        chk("rst_arvalid", bus.s_arvalid, 0);
        chk("rst_awvalid", bus.s_awvalid, 0);
        chk("rst_wvalid", bus.s_wvalid, 0);
        chk("rst_rready", bus.s_rready, 0);
        chk("rst_bready", bus.s_bready, 0);
        chk("rst_mready", {bus.m_arready, bus.m_awready, bus.m_wready}, 0);

        // Single M0 read, len=0
        bus.m_arvalid       = 2'b01;
        bus.m_araddr[31:0]  = 32'h0000_1000;
        bus.m_araddr[63:32] = 32'h7777_0000;
        bus.m_arsize        = 6'b011_010;
        bus.m_arburst       = 4'b10_01;
        bus.s_arready       = 1'b1;
        settle();
        chk("rd1_arb_cycle", bus.s_arvalid, 0);
        cyc();
        settle();
        chk("rd1_arvalid", bus.s_arvalid, 1);
        chk("rd1_arid", bus.s_arid, 0);
        chk("rd1_araddr", bus.s_araddr, 32'h0000_1000);
        chk("rd1_arlen", bus.s_arlen, 0);
        chk("rd1_arsize", bus.s_arsize, 2);
        chk("rd1_arburst", bus.s_arburst, 1);
        chk("rd1_arready", bus.m_arready, 2'b01);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.s_rvalid  = 1'b1;
        bus.s_rdata   = 32'hDEAD_BEEF;
        bus.s_rlast   = 1'b1;
        settle();
        chk("rd1_rvalid", bus.m_rvalid, 2'b01);
        chk("rd1_rdata", bus.m_rdata, 32'hDEAD_BEEF);
        chk("rd1_rready", bus.s_rready, 1);
        chk("rd1_addr_done", bus.s_arvalid, 0);
        cyc();
        settle();
        chk("rd1_idle_rvalid", bus.m_rvalid, 2'b00);
        chk("rd1_idle_rready", bus.s_rready, 0);

        // Round-robin fairness on simultaneous requests
        do_reset();
        bus.m_arvalid      = 2'b11;
        bus.m_araddr       = {32'hB0, 32'hA0};
        bus.m_rready       = 2'b11;
        bus.s_arready      = 1'b1;
        rd_txn(1'b0);
        rd_txn(1'b1);
        rd_txn(1'b0);

        // M1 write burst len=3 with early W and AW backpressure
        do_reset();
        bus.m_awvalid        = 2'b10;
        bus.m_awaddr[63:32]  = 32'h2000_0010;
        bus.m_awlen          = 16'h0300;
        bus.m_wvalid         = 2'b10;
        bus.m_wdata[63:32]   = 32'h100;
        bus.m_wstrb          = 8'hF0;
        bus.s_wready         = 1'b1;
        bus.m_bready         = 2'b11;
        settle();
        chk("wr_arb_awvalid", bus.s_awvalid, 0);
        cyc();
        settle();
        chk("wr_awvalid", bus.s_awvalid, 1);
        chk("wr_awaddr", bus.s_awaddr, 32'h2000_0010);
        chk("wr_awlen", bus.s_awlen, 3);
        chk("wr_awid", bus.s_awid, 1);
        chk("wr_awready_held", bus.m_awready, 2'b00);
        chk("wr_early_w_held", {bus.s_wvalid, bus.m_wready}, 0);
        cyc();
        settle();
        chk("wr_early_w_held2", {bus.s_wvalid, bus.m_wready}, 0);
        bus.s_awready = 1'b1;
        settle();
        chk("wr_awready", bus.m_awready, 2'b10);
        cyc();
        bus.m_awvalid = 2'b00;
        bus.s_awready = 1'b0;
        wb = 0;
        for (int i = 0; i < 4; i++) begin
            bus.m_wdata[63:32] = 32'h100 + i;
            bus.m_wlast        = (i == 3) ? 2'b10 : 2'b00;
            settle();
            chk("wr_wvalid", bus.s_wvalid, 1);
            chk("wr_wdata", bus.s_wdata, 32'h100 + i);
            chk("wr_wlast", bus.s_wlast, (i == 3) ? 1 : 0);
            chk("wr_wready", bus.m_wready, 2'b10);
            if (bus.s_wvalid && bus.s_wready) wb++;
            cyc();
        end
        chk("wr_beats", wb, 4);
        settle();
        chk("wr_no_extra_beat", bus.s_wvalid, 0);
        bus.m_wvalid = 2'b00;
        bus.m_wlast  = 2'b00;
        bus.s_bvalid = 1'b1;
        bus.s_bresp  = 2'b00;
        settle();
        chk("wr_bvalid", bus.m_bvalid, 2'b10);
        chk("wr_bresp", bus.m_bresp, 0);
        chk("wr_bready", bus.s_bready, 1);
        cyc();
        settle();
        chk("wr_idle_bvalid", bus.m_bvalid, 2'b00);
        bus.s_bvalid = 1'b0;

        // Concurrent M0 read len=7 (with rready backpressure) and M1 write len=1
        do_reset();
        bus.m_arvalid       = 2'b01;
        bus.m_araddr[31:0]  = 32'h3000;
        bus.m_arlen         = 16'h0007;
        bus.m_awvalid       = 2'b10;
        bus.m_awaddr[63:32] = 32'h4000;
        bus.m_awlen         = 16'h0100;
        bus.s_arready       = 1'b1;
        bus.s_awready       = 1'b1;
        bus.s_wready        = 1'b1;
        settle();
        chk("cc_arb_idle", {bus.s_arvalid, bus.s_awvalid}, 0);
        cyc();
        settle();
        chk("cc_arready", bus.m_arready, 2'b01);
        chk("cc_awready", bus.m_awready, 2'b10);
        chk("cc_ids", {bus.s_arid, bus.s_awid}, 8'h01);
        chk("cc_arlen", bus.s_arlen, 7);
        cyc();
        bus.m_arvalid = 2'b00;
        bus.m_awvalid = 2'b00;
        rb    = 0;
        wb    = 0;
        bdone = 1'b0;
        for (int c = 0; c < 20 && rb < 8; c++) begin
            rr             = !(c == 1 || c == 4);
            bus.m_rready   = {1'b1, rr};
            bus.s_rvalid   = 1'b1;
            bus.s_rdata    = 32'hC000 + rb;
            bus.s_rlast    = (rb == 7);
            if (wb < 2) begin
                bus.m_wvalid       = 2'b10;
                bus.m_wlast        = (wb == 1) ? 2'b10 : 2'b00;
                bus.m_wdata[63:32] = 32'h500 + wb;
                bus.s_bvalid       = 1'b0;
            end else begin
                bus.m_wvalid = 2'b00;
                bus.m_wlast  = 2'b00;
                bus.s_bvalid = 1'b1;
                bus.m_bready = 2'b11;
            end
            settle();
            chk("cc_rvalid", bus.m_rvalid, 2'b01);
            chk("cc_rready", bus.s_rready, rr);
            chk("cc_rdata", bus.m_rdata, 32'hC000 + rb);
            if (wb < 2) begin
                chk("cc_wready", bus.m_wready, 2'b10);
                chk("cc_wdata", bus.s_wdata, 32'h500 + wb);
                wb++;
            end else if (!bdone) begin
                chk("cc_bvalid", bus.m_bvalid, 2'b10);
                bdone = 1'b1;
            end else begin
                chk("cc_bvalid_idle", bus.m_bvalid, 2'b00);
            end
            if (rr) rb++;
            cyc();
        end
        chk("cc_read_beats", rb, 8);
        chk("cc_write_done", bdone, 1);
        bus.s_rlast = 1'b0;
        settle();
        chk("cc_read_idle", {bus.m_rvalid, bus.s_rready}, 0);
        bus.s_rvalid = 1'b0;
        bus.s_bvalid = 1'b0;

        // Reset in W_DATA after an M0 grant, then pointer must favour M0 again
        do_reset();
        bus.m_awvalid = 2'b01;
        bus.s_awready = 1'b1;
        bus.s_wready  = 1'b1;
        bus.m_bready  = 2'b11;
        cyc();
        cyc();
        bus.m_awvalid = 2'b00;
        bus.m_wvalid  = 2'b01;
        settle();
        chk("rw_in_wdata", bus.s_wvalid, 1);
        areset = 1'b1;
        cyc();
        settle();
        chk("rw_wvalid", bus.s_wvalid, 0);
        chk("rw_wready", bus.m_wready, 2'b00);
        chk("rw_aw", {bus.s_awvalid, bus.m_awready}, 0);
        chk("rw_bready", bus.s_bready, 0);
        areset        = 1'b0;
        bus.m_wvalid  = 2'b00;
        bus.m_awvalid = 2'b11;
        settle();
        chk("rw_arb_idle", bus.s_awvalid, 0);
        cyc();
        settle();
        chk("rw_tie_awid", bus.s_awid, 0);
        chk("rw_tie_awready", bus.m_awready, 2'b01);

        do_reset();
        bus.m_awvalid = 2'b10;
        bus.s_awready = 1'b1;
        cyc();
        settle();
        chk("rw_m1_awid", bus.s_awid, 1);
        chk("rw_m1_awready", bus.m_awready, 2'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
